// File: rtl/iterative_shift_ctrl_if.sv
//------------------------------------------------------------------------------
// iterative_shift_ctrl_if : start/ready handshake bundle for the shift unit
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface iterative_shift_ctrl_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               ctrl_start;
  logic               ctrl_op;
  logic [SHAMT_W-1:0] ctrl_shamt;
  logic [WIDTH-1:0]   data_operandA;
  logic [WIDTH-1:0]   data_result;
  logic               data_resultRDY;
  logic               busy;

  modport master (
    output ctrl_start, ctrl_op, ctrl_shamt, data_operandA,
    input  data_result, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_start, ctrl_op, ctrl_shamt, data_operandA,
    output data_result, data_resultRDY, busy
  );
endinterface

`default_nettype wire

// File: rtl/iterative_shift_ctrl.sv
//------------------------------------------------------------------------------
// iterative_shift_ctrl : multicycle SLL/SRA, one bit position per clock
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module iterative_shift_ctrl #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  wire logic            clock,
  input  wire logic            reset,
  iterative_shift_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_shreg;
  logic [SHAMT_W-1:0] r_count;
  logic               r_op;
  logic               r_rdy;
  logic               r_busy;

  assign bus.data_result    = r_shreg;
  assign bus.data_resultRDY = r_rdy;
  assign bus.busy           = r_busy;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_count <= '0;
      r_op    <= 1'b0;
      r_rdy   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          // DONE accepts a start directly so back-to-back ops lose no cycle
          r_rdy <= 1'b0;
          if (bus.ctrl_start) begin
            r_shreg <= bus.data_operandA;
            r_count <= bus.ctrl_shamt;
            r_op    <= bus.ctrl_op;
            r_state <= SHIFT;
            r_busy  <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        SHIFT: begin
          if (r_count != '0) begin
            if (r_op)
              r_shreg <= {r_shreg[WIDTH-1], r_shreg[WIDTH-1:1]};
            else
              r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
            r_count <= r_count - SHAMT_W'(1);
          end else begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_rdy   <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_rdy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_iterative_shift_ctrl.sv
//------------------------------------------------------------------------------
// tb_iterative_shift_ctrl : directed and random checks against a behavioural model
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_iterative_shift_ctrl;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  logic clock = 1'b0;
  logic reset = 1'b1;

  iterative_shift_ctrl_if #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) bus ();

  iterative_shift_ctrl #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mshift(input logic op, input logic [31:0] a, input int n);
    if (op) return 32'($signed(a) >>> n);
    return a << n;
  endfunction

  // Model: k counts edges since the accepting edge; busy while k<=shamt,
  // ready when k==shamt+1, result is the operand shifted by min(k,shamt).
  bit          m_active = 1'b0;
  logic        m_op;
  logic [31:0] m_a;
  int          m_sh;
  int          m_k;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_active = 1'b0;
    end else if (m_active && m_k <= m_sh) begin
      m_k++;
    end else if (bus.ctrl_start) begin
      m_active = 1'b1;
      m_op     = bus.ctrl_op;
      m_a      = bus.data_operandA;
      m_sh     = int'(bus.ctrl_shamt);
      m_k      = 0;
    end else if (m_active && m_k < 1000) begin
      m_k++;
    end
  end

  always @(posedge clock) begin
    #1;
    chk("busy", 32'(bus.busy), 32'(m_active && m_k <= m_sh));
    chk("rdy", 32'(bus.data_resultRDY), 32'(m_active && m_k == m_sh + 1));
    chk("result", bus.data_result,
        m_active ? mshift(m_op, m_a, (m_k < m_sh) ? m_k : m_sh) : 32'h0);
  end

  task automatic start_op(input logic op, input logic [31:0] a, input int sh);
    @(negedge clock);
    bus.ctrl_start    = 1'b1;
    bus.ctrl_op       = op;
    bus.ctrl_shamt    = SHAMT_W'(sh);
    bus.data_operandA = a;
    @(posedge clock);
    #2;
    bus.ctrl_start    = 1'b0;
    bus.ctrl_op       = 1'($urandom);
    bus.ctrl_shamt    = SHAMT_W'($urandom);
    bus.data_operandA = $urandom;
  endtask

  task automatic wait_rdy(input string name, input int exp_lat, input logic [31:0] exp_res);
    int  lat   = 0;
    int  bcnt  = 32'(bus.busy);
    bit  seen  = 1'b0;
    for (int i = 1; i <= 100 && !seen; i++) begin
      @(posedge clock);
      #2;
      if (bus.data_resultRDY) begin
        seen = 1'b1;
        lat  = i;
      end else if (bus.busy) begin
        bcnt++;
      end
    end
    chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({name, "_busy_cycles"}, 32'(bcnt), 32'(exp_lat));
    chk({name, "_value"}, bus.data_result, exp_res);
  endtask

  initial begin
    int pulses;
    int lat;
    logic [31:0] res;

    bus.ctrl_start    = 1'b0;
    bus.ctrl_op       = 1'b0;
    bus.ctrl_shamt    = '0;
    bus.data_operandA = '0;

    #2 reset = 1'b0;
    #1;
    chk("reset_result", bus.data_result, 32'h0);
    chk("reset_rdy", 32'(bus.data_resultRDY), 32'h0);
    chk("reset_busy", 32'(bus.busy), 32'h0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    start_op(1'b1, 32'h8000_0000, 4);
    wait_rdy("sra_neg4", 5, 32'hF800_0000);

    start_op(1'b0, 32'h0000_0001, 31);
    wait_rdy("sll_31", 32, 32'h8000_0000);
    start_op(1'b0, 32'h1234_5678, 0);
    wait_rdy("sll_0", 1, 32'h1234_5678);

    start_op(1'b1, 32'h7FFF_FFFF, 31);
    wait_rdy("sra_pos31", 32, 32'h0000_0000);
    start_op(1'b1, 32'hFFFF_FFF0, 2);
    wait_rdy("sra_neg2", 3, 32'hFFFF_FFFC);

    // Starts arriving mid-shift must be dropped
    start_op(1'b1, 32'h4000_0000, 8);
    pulses = 0;
    lat    = 0;
    res    = '0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clock);
      bus.ctrl_start    = (i == 2 || i == 5);
      bus.ctrl_op       = 1'b0;
      bus.ctrl_shamt    = SHAMT_W'(i);
      bus.data_operandA = 32'hDEAD_0000 + 32'(i);
      @(posedge clock);
      #2;
      bus.ctrl_start = 1'b0;
      if (bus.data_resultRDY) begin
        pulses++;
        if (pulses == 1) begin
          lat = i;
          res = bus.data_result;
        end
      end
    end
    chk("ignore_latency", 32'(lat), 32'd9);
    chk("ignore_value", res, 32'h0040_0000);
    chk("ignore_pulses", 32'(pulses), 32'd1);

    // New start held during the DONE cycle is accepted back-to-back
    start_op(1'b0, 32'h0000_0001, 3);
    wait_rdy("b2b_first", 4, 32'h0000_0008);
    start_op(1'b0, 32'h0000_0003, 1);
    wait_rdy("b2b_second", 2, 32'h0000_0006);

    // Asynchronous reset between edges in the middle of a shift
    start_op(1'b1, 32'h8765_4321, 20);
    repeat (5) @(posedge clock);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("async_result", bus.data_result, 32'h0);
    chk("async_busy", 32'(bus.busy), 32'h0);
    chk("async_rdy", 32'(bus.data_resultRDY), 32'h0);
    @(negedge clock);
    reset  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clock);
      #2;
      if (bus.data_resultRDY) pulses++;
    end
    chk("async_no_rdy", 32'(pulses), 32'd0);
    start_op(1'b0, 32'h0000_00F0, 4);
    wait_rdy("after_reset", 5, 32'h0000_0F00);

    // Random traffic, including starts during SHIFT and rare async resets
    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      bus.ctrl_start    = ($urandom_range(0, 2) == 0);
      bus.ctrl_op       = 1'($urandom);
      bus.ctrl_shamt    = ($urandom_range(0, 1) == 0) ? SHAMT_W'($urandom_range(0, 3))
                                                      : SHAMT_W'($urandom);
      bus.data_operandA = $urandom;
      if ($urandom_range(0, 599) == 0) begin
        #2 reset = 1'b0;
        #1 reset = 1'b1;
      end
    end
    @(negedge clock);
    bus.ctrl_start = 1'b0;
    repeat (40) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire
